// File: rtl/mem_pkg.sv
// Shared state encoding, size codes and requester ids for the RAM access controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    ACK    = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  localparam int MEM_BYTES_DFLT = 2048;

  // Only an explicit word request stays a word; 0, 1 and 3 all mean a single byte.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == SIZE_WORD) ? SIZE_WORD : SIZE_BYTE;
  endfunction

endpackage

// File: rtl/mem_arb.sv
// Fixed-priority pick between fetch and load/store: data port always wins, zero latency.
// Pure combinational; the loser simply keeps its request up until a later idle cycle.
module mem_arb
  import mem_pkg::*;
(
  input  logic    if_req_i,
  input  logic    mem_req_i,
  output logic    gnt_o,
  output req_id_e gnt_id_o
);

  always_comb begin
    gnt_o    = if_req_i | mem_req_i;
    gnt_id_o = mem_req_i ? REQ_MEM : REQ_IF;
  end

endmodule

// File: rtl/mem_ctrl.sv
// RAM access controller for fetch + load/store ports; ack 2 cycles after grant for stores, 3 for reads.
// Requesters hold req until ack. MEM_CTRL_BOUNDARY_CHECK_EN adds the address range check and O_fault.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_BYTES = MEM_BYTES_DFLT
) (
  input  logic              I_clk,
  input  logic              I_reset_n,
  input  logic              I_if_req,
  input  logic [ADDR_W-1:0] I_if_addr,
  output logic              O_if_ack,
  output logic [DATA_W-1:0] O_if_data,
  input  logic              I_mem_req,
  input  logic              I_mem_write,
  input  logic [1:0]        I_mem_size,
  input  logic [ADDR_W-1:0] I_mem_addr,
  input  logic [DATA_W-1:0] I_mem_data,
  output logic              O_mem_ack,
  output logic [DATA_W-1:0] O_mem_data,
  output logic              O_ram_enable,
  output logic              O_ram_write,
  output logic [1:0]        O_ram_size,
  output logic [ADDR_W-1:0] O_ram_addr,
  output logic [DATA_W-1:0] O_ram_data,
  input  logic [DATA_W-1:0] I_ram_data,
  output logic              O_busy
`ifdef MEM_CTRL_BOUNDARY_CHECK_EN
  ,
  output logic              O_fault
`endif
);

  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ram_cmd_t;

  state_e            state_q, state_d;
  req_id_e           gnt_id_q, gnt_id_d;
  ram_cmd_t          cmd_q, cmd_d;
  logic              oob_q, oob_d;
  logic              ram_en_q, ram_en_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0] if_dat_q, if_dat_d;
  logic [DATA_W-1:0] mem_dat_q, mem_dat_d;
  logic              busy_q, busy_d;

  logic              arb_gnt;
  req_id_e           arb_id;
  ram_cmd_t          req_cmd;
  logic              req_oob;
  logic [DATA_W-1:0] rd_word;

  mem_arb u_arb (
    .if_req_i  (I_if_req),
    .mem_req_i (I_mem_req),
    .gnt_o     (arb_gnt),
    .gnt_id_o  (arb_id)
  );

  // Fields of whichever requester the arbiter picked, already in RAM command form.
  always_comb begin
    req_cmd = '0;
    if (arb_id == REQ_MEM) begin
      req_cmd.write = I_mem_write;
      req_cmd.size  = norm_size(I_mem_size);
      req_cmd.addr  = I_mem_addr;
      req_cmd.data  = I_mem_data;
    end else begin
      req_cmd.write = 1'b0;
      req_cmd.size  = SIZE_WORD;
      req_cmd.addr  = I_if_addr;
      req_cmd.data  = '0;
    end
  end

`ifdef MEM_CTRL_BOUNDARY_CHECK_EN
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  logic [ADDR_W:0] last_byte;
  logic            fault_q, fault_d;

  // A word store touches addr+1 as well; reads at MEM_BYTES-1 are allowed and see 0 above the top.
  always_comb begin
    last_byte = {1'b0, req_cmd.addr};
    if (req_cmd.write && (req_cmd.size == SIZE_WORD)) begin
      last_byte = {1'b0, req_cmd.addr} + (ADDR_W+1)'(1);
    end
    req_oob = (last_byte >= MEM_LIMIT);
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_d = oob_q & (if_ack_d | mem_ack_d);
  assign O_fault = fault_q;
`else
  assign req_oob = 1'b0;

  // The RAM wraps addresses itself, so MEM_BYTES has no effect here beyond sanity.
  if (MEM_BYTES <= 0) begin : g_no_mem_bytes
  end
`endif

  always_comb begin
    rd_word = oob_q ? '0 : I_ram_data;
    if (cmd_q.size != SIZE_WORD) begin
      rd_word = oob_q ? '0 : DATA_W'(I_ram_data[7:0]);
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    cmd_d     = cmd_q;
    oob_d     = oob_q;
    ram_en_d  = 1'b0;
    if_ack_d  = 1'b0;
    mem_ack_d = 1'b0;
    if_dat_d  = if_dat_q;
    mem_dat_d = mem_dat_q;
    case (state_q)
      IDLE: begin
        if (arb_gnt) begin
          state_d  = ACCESS;
          gnt_id_d = arb_id;
          cmd_d    = req_cmd;
          oob_d    = req_oob;
          ram_en_d = !req_oob;
        end
      end
      ACCESS: begin
        if (cmd_q.write) begin
          state_d = ACK;
          if (gnt_id_q == REQ_MEM) mem_ack_d = 1'b1;
          else                     if_ack_d  = 1'b1;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        state_d = ACK;
        if (gnt_id_q == REQ_MEM) begin
          mem_ack_d = 1'b1;
          mem_dat_d = rd_word;
        end else begin
          if_ack_d = 1'b1;
          if_dat_d = rd_word;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q   <= IDLE;
      gnt_id_q  <= REQ_IF;
      cmd_q     <= '0;
      oob_q     <= 1'b0;
      ram_en_q  <= 1'b0;
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      if_dat_q  <= '0;
      mem_dat_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      cmd_q     <= cmd_d;
      oob_q     <= oob_d;
      ram_en_q  <= ram_en_d;
      if_ack_q  <= if_ack_d;
      mem_ack_q <= mem_ack_d;
      if_dat_q  <= if_dat_d;
      mem_dat_q <= mem_dat_d;
      busy_q    <= busy_d;
    end
  end

  assign O_ram_enable = ram_en_q;
  assign O_ram_write  = cmd_q.write;
  assign O_ram_size   = cmd_q.size;
  assign O_ram_addr   = cmd_q.addr;
  assign O_ram_data   = cmd_q.data;
  assign O_if_ack     = if_ack_q;
  assign O_if_data    = if_dat_q;
  assign O_mem_ack    = mem_ack_q;
  assign O_mem_data   = mem_dat_q;
  assign O_busy       = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-addressed RAM model with registered reads, plus a byte-array
// reference of memory contents; directed test-plan steps followed by a random transaction stream.
module tb_mem_ctrl;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int NMEM = 2048;

  logic          I_clk;
  logic          I_reset_n;
  logic          I_if_req;
  logic [AW-1:0] I_if_addr;
  logic          O_if_ack;
  logic [DW-1:0] O_if_data;
  logic          I_mem_req;
  logic          I_mem_write;
  logic [1:0]    I_mem_size;
  logic [AW-1:0] I_mem_addr;
  logic [DW-1:0] I_mem_data;
  logic          O_mem_ack;
  logic [DW-1:0] O_mem_data;
  logic          O_ram_enable;
  logic          O_ram_write;
  logic [1:0]    O_ram_size;
  logic [AW-1:0] O_ram_addr;
  logic [DW-1:0] O_ram_data;
  logic [DW-1:0] I_ram_data;
  logic          O_busy;
`ifdef MEM_CTRL_BOUNDARY_CHECK_EN
  logic          O_fault;
`endif

  mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_BYTES(NMEM)) dut (
    .I_clk        (I_clk),
    .I_reset_n    (I_reset_n),
    .I_if_req     (I_if_req),
    .I_if_addr    (I_if_addr),
    .O_if_ack     (O_if_ack),
    .O_if_data    (O_if_data),
    .I_mem_req    (I_mem_req),
    .I_mem_write  (I_mem_write),
    .I_mem_size   (I_mem_size),
    .I_mem_addr   (I_mem_addr),
    .I_mem_data   (I_mem_data),
    .O_mem_ack    (O_mem_ack),
    .O_mem_data   (O_mem_data),
    .O_ram_enable (O_ram_enable),
    .O_ram_write  (O_ram_write),
    .O_ram_size   (O_ram_size),
    .O_ram_addr   (O_ram_addr),
    .O_ram_data   (O_ram_data),
    .I_ram_data   (I_ram_data),
    .O_busy       (O_busy)
`ifdef MEM_CTRL_BOUNDARY_CHECK_EN
    ,
    .O_fault      (O_fault)
`endif
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // RAM model: 12-bit address wrap, bytes at or above NMEM read as 0 and ignore writes.
  logic [7:0] init_img [0:NMEM-1];
  logic [7:0] ram_b    [0:NMEM-1];
  logic [DW-1:0] ram_rd;
  bit ram_ready;

  assign I_ram_data = ram_rd;

  always @(posedge I_clk) begin : ram_model
    int ra;
    logic [7:0] lo, hi;
    ra = int'(O_ram_addr[11:0]);
    if (!ram_ready) begin
      for (int i = 0; i < NMEM; i++) ram_b[i] <= init_img[i];
      ram_ready <= 1'b1;
    end else if (O_ram_enable) begin
      if (O_ram_write) begin
        if (ra < NMEM) ram_b[ra] <= O_ram_data[7:0];
        if (O_ram_size == 2'd2 && ra + 1 < NMEM) ram_b[ra+1] <= O_ram_data[15:8];
      end else begin
        lo = (ra < NMEM) ? ram_b[ra] : 8'h00;
        hi = (O_ram_size == 2'd2 && ra + 1 < NMEM) ? ram_b[ra+1] : 8'h00;
        ram_rd <= {hi, lo};
      end
    end
  end

  // Reference contents of the RAM as the specification says they must evolve.
  logic [7:0] exp_mem [0:NMEM-1];
  logic [DW-1:0] last_if, last_mem;
  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a, input bit word);
    int ai;
    logic [7:0] lo, hi;
    ai = int'(a);
    lo = (ai < NMEM) ? exp_mem[ai] : 8'h00;
    hi = (word && ai + 1 < NMEM) ? exp_mem[ai+1] : 8'h00;
    return {hi, lo};
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [15:0] d, input bit word);
    int ai;
    ai = int'(a);
    if (ai < NMEM) exp_mem[ai] = d[7:0];
    if (word && ai + 1 < NMEM) exp_mem[ai+1] = d[15:8];
  endtask

  task automatic txn(input string tag, input bit is_fetch, input bit wr, input logic [1:0] sz,
                     input logic [15:0] addr, input logic [15:0] wdat);
    bit word, oob, store, got;
    int lat, exp_lat;
    logic [15:0] exp_d;
    store   = !is_fetch && wr;
    word    = is_fetch || (sz == 2'd2);
    oob     = 1'b0;
`ifdef MEM_CTRL_BOUNDARY_CHECK_EN
    oob = (store && word) ? (int'(addr) + 1 >= NMEM) : (int'(addr) >= NMEM);
`endif
    exp_lat = store ? 2 : 3;
    exp_d   = 16'h0000;
    if (store) begin
      if (!oob) model_write(addr, wdat, word);
    end else begin
      exp_d = oob ? 16'h0000 : model_read(addr, word);
    end

    @(negedge I_clk);
    check({tag, "/idle_busy"}, 32'(O_busy), 32'(0));
    if (is_fetch) begin
      I_if_req  = 1'b1;
      I_if_addr = addr;
    end else begin
      I_mem_req   = 1'b1;
      I_mem_write = wr;
      I_mem_size  = sz;
      I_mem_addr  = addr;
      I_mem_data  = wdat;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 12) begin
      @(negedge I_clk);
      lat++;
      check({tag, "/ram_en"}, 32'(O_ram_enable), 32'(lat == 1 && !oob));
      check({tag, "/busy"}, 32'(O_busy), 32'(1));
      check({tag, "/other_ack"}, 32'(is_fetch ? O_mem_ack : O_if_ack), 32'(0));
      got = is_fetch ? O_if_ack : O_mem_ack;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    if (got) begin
      if (is_fetch) begin
        check({tag, "/if_data"}, 32'(O_if_data), 32'(exp_d));
        check({tag, "/mem_data_held"}, 32'(O_mem_data), 32'(last_mem));
        last_if = exp_d;
      end else begin
        if (!store) begin
          check({tag, "/mem_data"}, 32'(O_mem_data), 32'(exp_d));
          last_mem = exp_d;
        end else begin
          check({tag, "/mem_data_held"}, 32'(O_mem_data), 32'(last_mem));
        end
        check({tag, "/if_data_held"}, 32'(O_if_data), 32'(last_if));
      end
`ifdef MEM_CTRL_BOUNDARY_CHECK_EN
      check({tag, "/fault"}, 32'(O_fault), 32'(oob));
`endif
    end
    I_if_req  = 1'b0;
    I_mem_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/ram_en"}, 32'(O_ram_enable), 32'(0));
    check({tag, "/ram_wr"}, 32'(O_ram_write), 32'(0));
    check({tag, "/ram_size"}, 32'(O_ram_size), 32'(0));
    check({tag, "/ram_addr"}, 32'(O_ram_addr), 32'(0));
    check({tag, "/ram_data"}, 32'(O_ram_data), 32'(0));
    check({tag, "/if_ack"}, 32'(O_if_ack), 32'(0));
    check({tag, "/mem_ack"}, 32'(O_mem_ack), 32'(0));
    check({tag, "/if_data"}, 32'(O_if_data), 32'(0));
    check({tag, "/mem_data"}, 32'(O_mem_data), 32'(0));
    check({tag, "/busy"}, 32'(O_busy), 32'(0));
`ifdef MEM_CTRL_BOUNDARY_CHECK_EN
    check({tag, "/fault"}, 32'(O_fault), 32'(0));
`endif
  endtask

  initial begin
    int mem_cyc, if_cyc, n_mem, n_if, kind;
    logic [15:0] ra, rd;
    logic [1:0] rs;
    logic [7:0] b;
    vectors     = 0;
    miscompares = 0;
    last_if     = '0;
    last_mem    = '0;
    I_reset_n   = 1'b1;
    I_if_req    = 1'b0;
    I_if_addr   = '0;
    I_mem_req   = 1'b0;
    I_mem_write = 1'b0;
    I_mem_size  = 2'd0;
    I_mem_addr  = '0;
    I_mem_data  = '0;
    for (int i = 0; i < NMEM; i++) begin
      b = 8'($urandom);
      init_img[i] = b;
      exp_mem[i]  = b;
    end
    // Bootloader image: 0x8000 at 0x0000, 0x8C00 at 0x0002 (little-endian words).
    init_img[0] = 8'h00; init_img[1] = 8'h80; init_img[2] = 8'h00; init_img[3] = 8'h8C;
    exp_mem[0]  = 8'h00; exp_mem[1]  = 8'h80; exp_mem[2]  = 8'h00; exp_mem[3]  = 8'h8C;

    #1 I_reset_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge I_clk);
    I_reset_n = 1'b1;

    txn("fetch0", 1'b1, 1'b0, 2'd2, 16'h0000, 16'h0);
    txn("fetch2", 1'b1, 1'b0, 2'd2, 16'h0002, 16'h0);
    txn("st_w100", 1'b0, 1'b1, 2'd2, 16'h0100, 16'h1234);
    txn("ld_w100", 1'b0, 1'b0, 2'd2, 16'h0100, 16'h0);
    txn("ld_b101", 1'b0, 1'b0, 2'd1, 16'h0101, 16'h0);
    txn("st_b200", 1'b0, 1'b1, 2'd0, 16'h0200, 16'hABCD);
    txn("ld_w200", 1'b0, 1'b0, 2'd2, 16'h0200, 16'h0);
    txn("ld_s3_200", 1'b0, 1'b0, 2'd3, 16'h0200, 16'h0);
    txn("ld_w7ff", 1'b0, 1'b0, 2'd2, 16'h07FF, 16'h0);

    // Simultaneous requests: data store wins, fetch follows after one idle cycle.
    model_write(16'h0300, 16'h5A5A, 1'b1);
    @(negedge I_clk);
    I_mem_req = 1'b1; I_mem_write = 1'b1; I_mem_size = 2'd2;
    I_mem_addr = 16'h0300; I_mem_data = 16'h5A5A;
    I_if_req = 1'b1; I_if_addr = 16'h0002;
    mem_cyc = 0; if_cyc = 0; n_mem = 0; n_if = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge I_clk);
      check("arb/both_ack", 32'(O_if_ack & O_mem_ack), 32'(0));
      if (O_mem_ack) begin n_mem++; mem_cyc = c; I_mem_req = 1'b0; end
      if (O_if_ack)  begin n_if++;  if_cyc  = c; I_if_req  = 1'b0; end
    end
    check("arb/n_mem", 32'(n_mem), 32'(1));
    check("arb/n_if", 32'(n_if), 32'(1));
    check("arb/mem_cyc", 32'(mem_cyc), 32'(2));
    check("arb/if_cyc", 32'(if_cyc), 32'(6));
    check("arb/if_data", 32'(O_if_data), 32'(16'h8C00));
    last_if = 16'h8C00;
    txn("ld_w300", 1'b0, 1'b0, 2'd2, 16'h0300, 16'h0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      ra   = 16'($urandom_range(16, NMEM - 2));
      rs   = 2'($urandom_range(0, 3));
      rd   = 16'($urandom);
      case (kind)
        0:       txn("rnd_fetch", 1'b1, 1'b0, 2'd2, ra, 16'h0);
        1:       txn("rnd_load", 1'b0, 1'b0, rs, ra, 16'h0);
        default: txn("rnd_store", 1'b0, 1'b1, rs, ra, rd);
      endcase
    end

    // Reset while a load is in ACCESS: everything drops at once and no ack follows.
    @(negedge I_clk);
    I_mem_req = 1'b1; I_mem_write = 1'b0; I_mem_size = 2'd2; I_mem_addr = 16'h0100;
    @(negedge I_clk);
    check("rst_mid/en_before", 32'(O_ram_enable), 32'(1));
    #1;
    I_reset_n = 1'b0;
    I_mem_req = 1'b0;
    #1 check_all_zero("rst_mid");
    for (int c = 0; c < 4; c++) begin
      @(negedge I_clk);
      check("rst_mid/no_ack", 32'(O_if_ack | O_mem_ack | O_ram_enable | O_busy), 32'(0));
    end
    I_reset_n = 1'b1;
    last_if  = '0;
    last_mem = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge I_clk);
      check("rst_mid/idle_after", 32'(O_if_ack | O_mem_ack | O_ram_enable), 32'(0));
    end
    txn("fetch_after_rst", 1'b1, 1'b0, 2'd2, 16'h0000, 16'h0);

    // Above the RAM top: faulted in the checked build, wrapped by the RAM otherwise.
    txn("ld_w900", 1'b0, 1'b0, 2'd2, 16'h0900, 16'h0);
    txn("st_w7ff", 1'b0, 1'b1, 2'd2, 16'h07FF, 16'h7E7E);
    txn("ld_b7ff", 1'b0, 1'b0, 2'd1, 16'h07FF, 16'h0);
    txn("st_b7ff", 1'b0, 1'b1, 2'd1, 16'h07FF, 16'h0042);
    txn("ld_w7ff_b", 1'b0, 1'b0, 2'd2, 16'h07FF, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory access controller sitting directly upstream of the byte-addressed RAM. It drives the RAM's enable, write, size, address and data inputs, and consumes its registered read data.
- Arbitrates between two CPU requesters: instruction fetch and load/store data. Each requester uses a req/ack handshake.
- Absorbs the RAM's one-cycle synchronous read latency so requesters see a single ack pulse with valid data.

Parameters:
- ADDR_W, 16, address width of all ports.
- DATA_W, 16, data width of all ports.
- MEM_BYTES, 2048, highest legal byte address + 1; used only by the optional boundary check.

Ports:
- I_clk  in  1  system clock, rising edge.
- I_reset_n  in  1  asynchronous, active-low reset.
- I_if_req  in  1  fetch request; held until O_if_ack.
- I_if_addr  in  ADDR_W  fetch byte address; fetch is always a 2-byte (word) read.
- O_if_ack  out  1  one-cycle pulse; O_if_data is valid in the same cycle.
- O_if_data  out  DATA_W  fetched word.
- I_mem_req  in  1  data request; held until O_mem_ack.
- I_mem_write  in  1  1 = store, 0 = load.
- I_mem_size  in  2  1 = byte, 2 = word; 0 and 3 are treated as byte.
- I_mem_addr  in  ADDR_W  data byte address.
- I_mem_data  in  DATA_W  store data; byte store uses [7:0].
- O_mem_ack  out  1  one-cycle completion pulse.
- O_mem_data  out  DATA_W  load result, valid with O_mem_ack; upper byte is 0 for byte loads.
- O_ram_enable  out  1  RAM enable.
- O_ram_write  out  1  RAM write strobe.
- O_ram_size  out  2  RAM size (1 or 2).
- O_ram_addr  out  ADDR_W  RAM address.
- O_ram_data  out  DATA_W  RAM write data.
- I_ram_data  in  DATA_W  RAM registered read data.
- O_busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered. Async reset (I_reset_n = 0) immediately forces state IDLE and every output to 0; O_ram_enable drops without waiting for a clock edge. Reset mid-access abandons the access: no ack is issued and the RAM side is idle after reset.
- States: IDLE, ACCESS, RDWAIT, ACK.
- IDLE:
  - Samples requests each edge. I_mem_req has fixed priority over I_if_req.
  - On grant, latch the requester id and the request fields into O_ram_*, set O_ram_enable = 1, and go to ACCESS.
  - Fetch grant drives O_ram_write = 0, O_ram_size = 2. Data size 0/3 is normalised to 1.
- ACCESS (one cycle, enable high): the RAM performs the operation at the closing edge. At that edge O_ram_enable is cleared. A write goes to ACK; a read goes to RDWAIT.
- RDWAIT (one cycle): at the closing edge, capture I_ram_data into the granted requester's data output, then go to ACK.
- ACK (one cycle): the granted requester's ack = 1; the other ack stays 0. Next state is IDLE.
- Latency, from the edge at which req is sampled in IDLE:
  - Store: ack is high in the 2nd cycle after that edge.
  - Load/fetch: ack is high in the 3rd cycle after that edge.
- Handshake rules:
  - The requester holds req and its fields stable until ack.
  - It must drop req in the ack cycle. If req is still high at the ACK→IDLE edge, it is sampled again in IDLE as a new request.
  - The loser of simultaneous requests keeps req high and is served in the next IDLE, so there is no lost request.
- Starvation: continuous back-to-back data requests may starve fetch. This is accepted because the CPU never issues data requests while waiting on fetch.
- O_*_data holds its last captured value between acks. The ungranted port's data output is never modified.
- Word access at address MEM_BYTES-1 is passed through unchanged; the RAM returns 0 in the upper byte.

Optional Feature:
- Macro MEM_CTRL_BOUNDARY_CHECK_EN.
- Defined:
  - A request with addr >= MEM_BYTES (or addr + 1 >= MEM_BYTES for a word store) is not sent to the RAM; O_ram_enable stays 0.
  - The FSM still walks ACCESS→(RDWAIT)→ACK with the same latency, so timing is identical to a legal access.
  - A read returns 0.
  - Adds output port O_fault (1 bit), pulsed together with the ack.
- Undefined: no check, no O_fault port; addresses pass straight through and the RAM truncates them to 12 bits.

Decomposition:
- Package mem_pkg holds:
  - the state encoding (IDLE/ACCESS/RDWAIT/ACK);
  - constants SIZE_BYTE = 1, SIZE_WORD = 2;
  - requester ids REQ_IF = 0, REQ_MEM = 1;
  - the MEM_BYTES default.
- Sub-module mem_arb: a two-input fixed-priority arbiter producing grant and id, used only in IDLE. The FSM and datapath stay in mem_ctrl.

Test Plan:
- Reset, then fetch with I_if_addr = 0x0000 against the bootloader image -> O_if_ack in the 3rd cycle, O_if_data = 0x8000. Repeat at addr 0x0002 -> 0x8C00.
- Word store 0x1234 to 0x0100, then word load from 0x0100 -> store ack in the 2nd cycle; load O_mem_data = 0x1234. Byte load from 0x0101 -> 0x0012.
- Byte store 0xABCD at 0x0200 with size 0, then word load -> upper byte unchanged; low byte = 0xCD.
- I_if_req and I_mem_req asserted in the same cycle -> mem is served first, then fetch; exactly one ack each, never both in one cycle.
- I_reset_n pulled low during ACCESS of a load -> O_ram_enable = 0 immediately, no ack, O_busy = 0. After release, a fresh fetch completes normally.
- With MEM_CTRL_BOUNDARY_CHECK_EN, load from 0x0900 -> O_ram_enable never asserted, O_mem_data = 0, O_fault pulses with O_mem_ack in the 3rd cycle.
